// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package wide_add_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_CHUNKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Bit offset of chunk idx inside a packed multi-chunk operand.
  function automatic int chunk_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wide_add_chunk_sel.sv
// Chunk mux feeding the adder operands and one-hot write-enable decode
// for the reassembled sum register.
module wide_add_chunk_sel
  import wide_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS,
  parameter int IDXW   = $clog2(CHUNKS)
) (
  input  logic                    sel_en,
  input  logic [IDXW-1:0]         sel_idx,
  input  logic [WIDTH*CHUNKS-1:0] op_a,
  input  logic [WIDTH*CHUNKS-1:0] op_b,
  output logic [WIDTH-1:0]        chunk_a,
  output logic [WIDTH-1:0]        chunk_b,
  input  logic                    wr_en,
  input  logic [IDXW-1:0]         wr_idx,
  output logic [CHUNKS-1:0]       wr_we
);

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    wr_we   = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (sel_en && (sel_idx == IDXW'(i))) begin
        chunk_a = op_a[chunk_lsb(i, WIDTH) +: WIDTH];
        chunk_b = op_b[chunk_lsb(i, WIDTH) +: WIDTH];
      end
      if (wr_en && (wr_idx == IDXW'(i))) begin
        wr_we[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add sequencer driving an external registered adder chunk by chunk.
// Optional signed-overflow output out_ovf is enabled by defining WIDE_ADD_OVF_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS,
  parameter int IDXW   = $clog2(CHUNKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*CHUNKS-1:0] in_a,
  input  logic [WIDTH*CHUNKS-1:0] in_b,
  input  logic                    in_cin,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_s,
  input  logic                    add_cout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*CHUNKS-1:0] out_sum,
  output logic                    out_cout
`ifdef WIDE_ADD_OVF_EN
  ,
  output logic                    out_ovf
`endif
);

  localparam int TOT = WIDTH * CHUNKS;
  localparam logic [IDXW-1:0] LAST = IDXW'(CHUNKS - 1);

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [TOT-1:0]      a_q, a_d;
  logic [TOT-1:0]      b_q, b_d;
  logic                cin_q, cin_d;
  logic [TOT-1:0]      sum_q, sum_d;
  logic                cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  logic                issue_en;
  logic                wr_en;
  logic [IDXW-1:0]     wr_idx;
  logic [CHUNKS-1:0]   sum_we;
  logic [WIDTH-1:0]    chunk_a, chunk_b;

  wide_add_chunk_sel #(
    .WIDTH  (WIDTH),
    .CHUNKS (CHUNKS),
    .IDXW   (IDXW)
  ) u_chunk_sel (
    .sel_en  (issue_en),
    .sel_idx (idx_q),
    .op_a    (a_q),
    .op_b    (b_q),
    .chunk_a (chunk_a),
    .chunk_b (chunk_b),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_we   (sum_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    cout_d   = cout_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    issue_en = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = idx_q - IDXW'(1);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_en = !rst;
        // Sum of the previous chunk arrives one cycle after its issue.
        wr_en    = (idx_q != '0);
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wr_en   = 1'b1;
        wr_idx  = LAST;
        cout_d  = add_cout;
`ifdef WIDE_ADD_OVF_EN
        ovf_d   = (a_q[TOT-1] == b_q[TOT-1]) && (add_s[WIDTH-1] != a_q[TOT-1]);
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < CHUNKS; i++) begin
      if (sum_we[i]) sum_d[chunk_lsb(i, WIDTH) +: WIDTH] = add_s;
    end
  end

  assign add_a     = chunk_a;
  assign add_b     = chunk_b;
  assign add_cin   = issue_en ? ((idx_q == '0) ? cin_q : add_cout) : 1'b0;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq with a behavioural registered 64-bit adder and a result scoreboard.
module tb_wide_add_seq;

  localparam int W = 64;
  localparam int C = 4;
  localparam int T = W * C;

  typedef struct {
    logic [T-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [T-1:0] in_a;
  logic [T-1:0] in_b;
  logic         in_cin;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [T-1:0] out_sum;
  logic         out_cout;
`ifdef WIDE_ADD_OVF_EN
  logic         out_ovf;
`endif

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef WIDE_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // Behavioural stand-in for the registered adder: one-cycle latency, no reset.
  logic [W:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  always @(posedge clk) begin
    add_s    <= adder_full[W-1:0];
    add_cout <= adder_full[W];
  end

  function automatic logic [T-1:0] rand_wide();
    logic [T-1:0] r;
    for (int i = 0; i < T / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one operand pair, records its expected result, returns #1 after the accept edge.
  task automatic send_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic c);
    exp_t         e;
    logic [T:0]   full;
    int           n;
    full   = {1'b0, a} + {1'b0, b} + {{T{1'b0}}, c};
    e.sum  = full[T-1:0];
    e.cout = full[T];
    e.ovf  = (a[T-1] == b[T-1]) && (full[T-1] != a[T-1]);
    sb_q.push_back(e);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b want 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~c;
  endtask

  // Cycle 1 is the one following the accept edge; returns once out_valid is seen or budget expires.
  task automatic wait_result(output logic got, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_valid;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got=%0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want 0", out_valid); end
    checks++; if (out_sum !== '0)     begin errors++; $display("FAIL rst_out_sum got=%h want 0", out_sum); end
    checks++; if (out_cout !== 1'b0)  begin errors++; $display("FAIL rst_out_cout got=%0b want 0", out_cout); end
    checks++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL rst_add_ports a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin);
    end
`ifdef WIDE_ADD_OVF_EN
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL rst_out_ovf got=%0b want 0", out_ovf); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_in();
    exp_t e; logic got; int lat;
    send_op({T{1'b1}}, '0, 1'b1);
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1)      begin errors++; $display("FAIL cin_valid got=%0b want 1", got); end
    checks++; if (lat != C + 2)      begin errors++; $display("FAIL cin_latency got=%0d want %0d", lat, C + 2); end
    checks++; if (out_sum !== e.sum) begin errors++; $display("FAIL cin_sum got=%h want %h", out_sum, e.sum); end
    checks++; if (out_cout !== e.cout) begin errors++; $display("FAIL cin_cout got=%0b want %0b", out_cout, e.cout); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL cin_release in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_small();
    exp_t e; logic got; int lat;
    logic [C-1:0] cin_log;
    logic [W-1:0] a_log [C];
    logic [W-1:0] b_log [C];
    send_op(T'(1), T'(2), 1'b0);
    for (int k = 0; k < C; k++) begin
      cin_log[k] = add_cin;
      a_log[k]   = add_a;
      b_log[k]   = add_b;
      @(posedge clk); #1;
    end
    checks++; if (cin_log !== '0) begin errors++; $display("FAIL small_add_cin got=%b want 0000", cin_log); end
    checks++; if (a_log[0] !== W'(1) || b_log[0] !== W'(2)) begin
      errors++; $display("FAIL small_chunk0 a=%h b=%h want 1/2", a_log[0], b_log[0]);
    end
    checks++; if (a_log[1] !== '0 || b_log[3] !== '0) begin
      errors++; $display("FAIL small_upper_chunks a1=%h b3=%h want 0", a_log[1], b_log[3]);
    end
    checks++; if (add_a !== '0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL small_drain_ports a=%h cin=%0b want 0", add_a, add_cin);
    end
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++; $display("FAIL small_result valid=%0b sum=%h cout=%0b want 1 %h %0b", got, out_sum, out_cout, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_chunk_carry();
    exp_t e; logic got; int lat;
    logic [C-1:0] cin_log;
    logic [T-1:0] a;
    a = '0;
    a[W-1:0] = {W{1'b1}};
    send_op(a, T'(1), 1'b0);
    for (int k = 0; k < C; k++) begin
      cin_log[k] = add_cin;
      @(posedge clk); #1;
    end
    checks++; if (cin_log !== 4'b0010) begin errors++; $display("FAIL chain_add_cin got=%b want 0010", cin_log); end
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++; $display("FAIL chain_result valid=%0b sum=%h cout=%0b want 1 %h %0b", got, out_sum, out_cout, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e; logic got; int lat; int bad;
    out_ready = 1'b0;
    send_op(rand_wide(), rand_wide(), 1'b1);
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0b want 1", got); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum || out_cout !== e.cout) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d want 0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
    send_op(rand_wide(), rand_wide(), 1'b0);
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1 || lat != C + 2 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++; $display("FAIL b2b_result valid=%0b lat=%0d sum=%h cout=%0b want 1 %0d %h %0b", got, lat, out_sum, out_cout, C + 2, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e; exp_t dropped; logic got; int lat; int seen;
    send_op(rand_wide(), rand_wide(), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL mid_rst_add_ports a=%h b=%h cin=%0b want 0", add_a, add_b, add_cin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = sb_q.pop_back();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== '0) begin
      errors++; $display("FAIL mid_rst_release out_valid=%0b in_ready=%0b add_a=%h want 0/1/0", out_valid, in_ready, add_a);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_ghost out_valid_cycles=%0d want 0 (dropped sum %h)", seen, dropped.sum); end
    send_op(T'(5), T'(7), 1'b0);
    wait_result(got, lat);
    e = sb_q.pop_front();
    checks++; if (got !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++; $display("FAIL mid_rst_new_op valid=%0b sum=%h cout=%0b want 1 %h %0b", got, out_sum, out_cout, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    exp_t e; logic got; int lat;
    logic [T-1:0] a_tab [3];
    logic [T-1:0] b_tab [3];
    a_tab[0] = {1'b0, {(T-1){1'b1}}}; b_tab[0] = T'(1);
    a_tab[1] = {T{1'b1}};             b_tab[1] = T'(1);
    a_tab[2] = rand_wide();           b_tab[2] = rand_wide();
    for (int k = 0; k < 3; k++) begin
      send_op(a_tab[k], b_tab[k], 1'b0);
      wait_result(got, lat);
      e = sb_q.pop_front();
      checks++; if (got !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout) begin
        errors++; $display("FAIL ovf_case%0d_result valid=%0b sum=%h cout=%0b want 1 %h %0b", k, got, out_sum, out_cout, e.sum, e.cout);
      end
`ifdef WIDE_ADD_OVF_EN
      checks++; if (out_ovf !== e.ovf) begin
        errors++; $display("FAIL ovf_case%0d_flag got=%0b want %0b", k, out_ovf, e.ovf);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    exp_t e; logic got; int lat;
    for (int k = 0; k < 4; k++) begin
      send_op(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)));
      wait_result(got, lat);
      e = sb_q.pop_front();
      checks++; if (got !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout) begin
        errors++; $display("FAIL rand%0d_result valid=%0b sum=%h cout=%0b want 1 %h %0b", k, got, out_sum, out_cout, e.sum, e.cout);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_carry_in();
    test_small();
    test_chunk_carry();
    test_back_to_back();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
